fifo_write_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one FIFO write port between N_REQ producers. It sits directly in front of the FIFO and grants one producer at a time for a bounded burst of writes. It drives the FIFO's write strobe and data from the granted producer. It mirrors the FIFO's acceptance rule: a write is taken when the FIFO is not full, or when it is full and a read happens in the same cycle.

---
 rtl/fifo_write_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with bounded bursts per grant.
// Optional per-producer accepted-write counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     fifo_full,
  input  logic                     fifo_read,
  output logic                     fifo_write,
  output logic [WIDTH-1:0]         fifo_wdata,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic [N_REQ*16-1:0]      stat_cnt
);

  // state | meaning
  // IDLE  | no producer granted; arbitrate among req_valid starting at rr_ptr
  // GRANT | producer g_idx owns the write port until it drops valid or hits MAX_BURST
  typedef enum logic {IDLE, GRANT} state_t;

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   grant_nxt;
  logic [PTR_W-1:0]   g_idx, g_idx_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [BC_W-1:0]    burst_cnt, burst_cnt_nxt;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic               accept;
  logic               wr_en;
  int                 cand;

  assign accept = ~fifo_full | fifo_read;
  assign busy   = (state == GRANT);

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    g_idx_nxt     = g_idx;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    wr_en         = 1'b0;
    fifo_wdata    = '0;
    req_ready     = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt     = GRANT;
          grant_nxt     = N_REQ'(1) << win_idx;
          g_idx_nxt     = win_idx;
          burst_cnt_nxt = '0;
        end
      end
      GRANT: begin
        wr_en             = req_valid[g_idx] & accept & ~reset;
        fifo_wdata        = req_data[g_idx*WIDTH +: WIDTH];
        req_ready[g_idx]  = wr_en;
        if (wr_en) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
        if (!req_valid[g_idx] || (wr_en && burst_cnt == BC_W'(MAX_BURST - 1))) begin
          state_nxt     = IDLE;
          grant_nxt     = '0;
          burst_cnt_nxt = '0;
          rr_ptr_nxt    = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign fifo_write = wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      g_idx     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      g_idx     <= g_idx_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    always_ff @(posedge clk) begin
      if (reset) begin
        stat_q[i] <= '0;
      end else if (req_ready[i] && stat_q[i] != 16'hFFFF) begin
        stat_q[i] <= stat_q[i] + 16'd1;
      end
    end
    assign stat_cnt[i*16 +: 16] = stat_q[i];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4); expectations are hand-computed.
module tb_fifo_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_read;
  logic        fifo_write;
  logic [7:0]  fifo_wdata;
  logic [3:0]  grant;
  logic        busy;
  logic [63:0] stat_cnt;

  int total = 0;
  int bad   = 0;

  fifo_write_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_read(fifo_read),
    .fifo_write(fifo_write), .fifo_wdata(fifo_wdata), .grant(grant),
    .busy(busy), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    fifo_full = 1'b0;
    fifo_read = 1'b0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
  endtask

  logic [3:0]  exp_g;
  logic        exp_w;
  logic [7:0]  exp_d;
  logic [63:0] exp_stat;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = 32'h44_33_22_11;
    fifo_full = 1'b0;
    fifo_read = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_write", 64'(fifo_write), 64'h0);
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_wdata", 64'(fifo_wdata), 64'h0);
    chk("rst_stat", stat_cnt, 64'h0);

    // single producer 1, period 5: idle + 4 writes
    req_data  = 32'h00_00_5A_00;
    req_valid = 4'b0010;
    settle();
    chk("sp_idle_write", 64'(fifo_write), 64'h0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_w = (c % 5) != 0;
      exp_g = exp_w ? 4'b0010 : 4'b0000;
      chk("sp_grant", 64'(grant), 64'(exp_g));
      chk("sp_write", 64'(fifo_write), 64'(exp_w));
      chk("sp_ready", 64'(req_ready), 64'(exp_g));
      chk("sp_busy", 64'(busy), 64'(exp_w));
    end

    // round robin 0,1,2,3,0,... each 4 writes, 40 cycles
    do_reset();
    req_data  = 32'h44_33_22_11;
    req_valid = 4'b1111;
    settle();
    chk("rr_idle0", 64'(grant), 64'h0);
    for (int c = 1; c <= 40; c++) begin
      tick();
      exp_w = (c % 5) != 0;
      exp_g = exp_w ? (4'b0001 << ((c / 5) % 4)) : 4'b0000;
      exp_d = exp_w ? 8'(8'h11 * (((c / 5) % 4) + 1)) : 8'h00;
      chk("rr_grant", 64'(grant), 64'(exp_g));
      chk("rr_write", 64'(fifo_write), 64'(exp_w));
      chk("rr_wdata", 64'(fifo_wdata), 64'(exp_d));
    end
`ifdef FIFO_ARB_STATS_EN
    exp_stat = {16'd8, 16'd8, 16'd8, 16'd8};
`else
    exp_stat = 64'h0;
`endif
    chk("stat_after_rr", stat_cnt, exp_stat);

    // backpressure on producer 2
    do_reset();
    req_data  = 32'h00_C3_00_00;
    req_valid = 4'b0100;
    tick();
    settle();
    chk("bp_first_write", 64'(fifo_write), 64'h1);
    chk("bp_wdata", 64'(fifo_wdata), 64'hC3);
    for (int c = 0; c < 3; c++) begin
      tick();
      fifo_full = 1'b1;
      fifo_read = 1'b0;
      settle();
      chk("bp_full_write", 64'(fifo_write), 64'h0);
      chk("bp_full_ready", 64'(req_ready), 64'h0);
      chk("bp_full_grant", 64'(grant), 64'b0100);
    end
    tick();
    fifo_read = 1'b1;
    settle();
    chk("bp_fullrd_write", 64'(fifo_write), 64'h1);
    chk("bp_fullrd_ready", 64'(req_ready), 64'b0100);
    tick();
    fifo_full = 1'b0;
    fifo_read = 1'b0;
    settle();
    chk("bp_w3", 64'(fifo_write), 64'h1);
    tick();
    settle();
    chk("bp_w4", 64'(fifo_write), 64'h1);
    chk("bp_w4_grant", 64'(grant), 64'b0100);
    tick();
    settle();
    chk("bp_release_grant", 64'(grant), 64'h0);
    chk("bp_release_busy", 64'(busy), 64'h0);
    req_valid = '0;

    // early release of producer 0, then producer 3
    do_reset();
    req_data  = 32'hB3_00_00_A0;
    req_valid = 4'b1001;
    tick();
    settle();
    chk("er_grant0", 64'(grant), 64'b0001);
    chk("er_wdata0", 64'(fifo_wdata), 64'hA0);
    tick();
    settle();
    chk("er_w2", 64'(fifo_write), 64'h1);
    tick();
    req_valid = 4'b1000;
    settle();
    chk("er_drop_write", 64'(fifo_write), 64'h0);
    chk("er_drop_grant", 64'(grant), 64'b0001);
    tick();
    settle();
    chk("er_idle_grant", 64'(grant), 64'h0);
    chk("er_idle_busy", 64'(busy), 64'h0);
    tick();
    settle();
    chk("er_grant3", 64'(grant), 64'b1000);
    chk("er_wdata3", 64'(fifo_wdata), 64'hB3);
    chk("er_ready3", 64'(req_ready), 64'b1000);

    // reset in the middle of a producer-1 burst
    do_reset();
    req_data  = 32'h44_33_22_11;
    req_valid = 4'b0010;
    tick();
    settle();
    chk("mr_w1", 64'(fifo_write), 64'h1);
    tick();
    settle();
    chk("mr_w2", 64'(fifo_write), 64'h1);
    tick();
    req_valid = 4'b1111;
    reset     = 1'b1;
    settle();
    chk("mr_rst_write", 64'(fifo_write), 64'h0);
    chk("mr_rst_ready", 64'(req_ready), 64'h0);
    tick();
    reset = 1'b0;
    settle();
    chk("mr_idle_grant", 64'(grant), 64'h0);
    chk("mr_idle_busy", 64'(busy), 64'h0);
    chk("mr_idle_write", 64'(fifo_write), 64'h0);
    tick();
    settle();
    chk("mr_regrant0", 64'(grant), 64'b0001);
    chk("mr_regrant_wdata", 64'(fifo_wdata), 64'h11);
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
